// File: rtl/round_judge.sv
// Round judge: prep timer, LFSR target generator and hit/miss scoring FSM.
// A round is won by holding the position inside the tolerance window long enough.
module round_judge #(
  parameter int          PREP_MS    = 1000,
  parameter int          HOLD_MS    = 500,
  parameter int          TIMEOUT_MS = 5000,
  parameter logic [7:0]  SEED       = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_ms,
  input  logic       prep_en,
  input  logic       gerar_nova_jogada,
  input  logic       conta_nivel,
  input  logic       reset_pontos,
  input  logic [1:0] nivel,
  input  logic [7:0] posicao,
  output logic       prep_done,
  output logic       ponto_evento,
  output logic       acerto,
  output logic [7:0] alvo,
  output logic [7:0] pontos,
  output logic [1:0] db_estado
);

  localparam int PW = $clog2(PREP_MS + 1);
  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int TW = $clog2(TIMEOUT_MS + 1);

  localparam logic [PW-1:0] PREP_MAX  = PW'(PREP_MS);
  localparam logic [PW-1:0] PREP_LAST = PW'(PREP_MS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_MS);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_MS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_PLAY   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   prep_cnt_q, prep_cnt_d;
  logic            prep_done_q, prep_done_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [7:0]      alvo_q, alvo_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            pe_q, pe_d;
  logic            acerto_q, acerto_d;
  logic [7:0]      pontos_q, pontos_d;

  logic            fb;
  logic [7:0]      lfsr_nxt;
  logic [7:0]      tol;
  logic signed [8:0] diff;
  logic [8:0]      mag;
  logic            in_window;
  logic [HW-1:0]   hold_inc;
  logic [TW-1:0]   tmo_inc;

  // Prep timer saturates so prep_done fires once per prep_en assertion.
  always_comb begin
    prep_cnt_d  = prep_cnt_q;
    prep_done_d = 1'b0;
    if (!prep_en) begin
      prep_cnt_d = '0;
    end else if (tick_ms && (prep_cnt_q != PREP_MAX)) begin
      prep_cnt_d  = prep_cnt_q + PW'(1);
      prep_done_d = (prep_cnt_q == PREP_LAST);
    end
  end

  always_comb begin
    fb       = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_nxt = {lfsr_q[6:0], fb};
    lfsr_d   = (lfsr_nxt == 8'd0) ? SEED : lfsr_nxt;
  end

  always_comb begin
    tol = 8'd16;
    unique case (nivel)
      2'd0: tol = 8'd16;
      2'd1: tol = 8'd12;
      2'd2: tol = 8'd8;
      2'd3: tol = 8'd4;
    endcase
  end

  // Distance is taken in 9 bits so positions far apart never alias.
  always_comb begin
    diff      = $signed({1'b0, posicao}) - $signed({1'b0, alvo_q});
    mag       = diff[8] ? 9'(-diff) : 9'(diff);
    in_window = (mag <= {1'b0, tol});
    hold_inc  = in_window ? (hold_q + HW'(1)) : '0;
    tmo_inc   = tmo_q + TW'(1);
  end

  always_comb begin
    state_d  = state_q;
    alvo_d   = alvo_q;
    hold_d   = hold_q;
    tmo_d    = tmo_q;
    acerto_d = acerto_q;
    pontos_d = pontos_q;
    pe_d     = 1'b0;

    if (gerar_nova_jogada) begin
      alvo_d  = 8'd64 + {1'b0, lfsr_q[6:0]};
      hold_d  = '0;
      tmo_d   = '0;
      state_d = S_WAIT;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_WAIT: begin
          if (conta_nivel) state_d = S_PLAY;
        end
        S_PLAY: begin
          if (!conta_nivel) begin
            state_d = S_IDLE;
          end else if (tick_ms) begin
            hold_d = hold_inc;
            tmo_d  = tmo_inc;
            if (hold_inc == HOLD_MAX) begin
              state_d  = S_REPORT;
              acerto_d = 1'b1;
            end else if (tmo_inc == TMO_MAX) begin
              state_d  = S_REPORT;
              acerto_d = 1'b0;
            end
          end
        end
        S_REPORT: state_d = S_IDLE;
      endcase
    end

    if ((state_q == S_REPORT) && acerto_q && (pontos_q != 8'hFF)) begin
      pontos_d = pontos_q + 8'd1;
    end
    if (reset_pontos) pontos_d = 8'd0;

    pe_d = (state_d == S_REPORT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prep_cnt_q  <= '0;
      prep_done_q <= 1'b0;
      lfsr_q      <= SEED;
      alvo_q      <= 8'd128;
      hold_q      <= '0;
      tmo_q       <= '0;
      pe_q        <= 1'b0;
      acerto_q    <= 1'b0;
      pontos_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      prep_cnt_q  <= prep_cnt_d;
      prep_done_q <= prep_done_d;
      lfsr_q      <= lfsr_d;
      alvo_q      <= alvo_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      pe_q        <= pe_d;
      acerto_q    <= acerto_d;
      pontos_q    <= pontos_d;
    end
  end

  assign prep_done    = prep_done_q;
  assign ponto_evento = pe_q;
  assign acerto       = acerto_q;
  assign alvo         = alvo_q;
  assign pontos       = pontos_q;
  assign db_estado    = state_q;

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge: vector table, hand sequences and random rounds
// checked against a run-length round model.
module tb_round_judge;

  localparam int         PREP = 4;
  localparam int         HOLD = 3;
  localparam int         TMO  = 10;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick_ms;
  logic       prep_en;
  logic       gerar_nova_jogada;
  logic       conta_nivel;
  logic       reset_pontos;
  logic [1:0] nivel;
  logic [7:0] posicao;
  logic       prep_done;
  logic       ponto_evento;
  logic       acerto;
  logic [7:0] alvo;
  logic [7:0] pontos;
  logic [1:0] db_estado;

  int n_cmp = 0;
  int n_bad = 0;
  int pontos_m = 0;
  logic [7:0] alvo_m = 8'd128;
  logic [7:0] lfsr_m;

  always #5 clock = ~clock;

  round_judge #(
    .PREP_MS(PREP), .HOLD_MS(HOLD), .TIMEOUT_MS(TMO), .SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .tick_ms(tick_ms), .prep_en(prep_en),
    .gerar_nova_jogada(gerar_nova_jogada), .conta_nivel(conta_nivel),
    .reset_pontos(reset_pontos), .nivel(nivel), .posicao(posicao),
    .prep_done(prep_done), .ponto_evento(ponto_evento), .acerto(acerto),
    .alvo(alvo), .pontos(pontos), .db_estado(db_estado)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) lfsr_m <= SEED;
    else       lfsr_m <= lfsr_step(lfsr_m);
  end

  typedef struct {
    int         nv;
    logic [7:0] tgt;
    logic [7:0] pos;
    bit         hit;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_tick();
    tick_ms = 1'b1;
    cyc();
    tick_ms = 1'b0;
  endtask

  task automatic gen_any();
    logic [7:0] e;
    e = 8'd64 + {1'b0, lfsr_m[6:0]};
    gerar_nova_jogada = 1'b1;
    cyc();
    gerar_nova_jogada = 1'b0;
    alvo_m = e;
    chk("alvo_load", int'(alvo), int'(e));
    chk("alvo_range", int'(alvo >= 8'd64 && alvo <= 8'd191), 1);
    chk("wait_state", int'(db_estado), 1);
  endtask

  task automatic gen_target(input logic [7:0] t);
    int k;
    k = 0;
    while (((8'd64 + {1'b0, lfsr_m[6:0]}) != t) && (k < 600)) begin
      cyc();
      k++;
    end
    if (k >= 600) chk("target_wait", 0, 1);
    gen_any();
  endtask

  task automatic start_play();
    conta_nivel = 1'b1;
    cyc();
    chk("play_state", int'(db_estado), 2);
  endtask

  task automatic finish_report(input bit hit, input string nm);
    chk({nm, "_acerto"}, int'(acerto), int'(hit));
    chk({nm, "_report"}, int'(db_estado), 3);
    if (hit && pontos_m < 255) pontos_m++;
    cyc();
    chk({nm, "_pontos"}, int'(pontos), pontos_m);
    chk({nm, "_pe_low"}, int'(ponto_evento), 0);
    chk({nm, "_idle"}, int'(db_estado), 0);
  endtask

  task automatic const_round(input int nv, input logic [7:0] pos,
                             input bit hit, input string nm);
    int n;
    nivel   = 2'(nv);
    posicao = pos;
    n = hit ? HOLD : TMO;
    for (int k = 1; k <= n; k++) begin
      do_tick();
      chk({nm, "_pe"}, int'(ponto_evento), int'(k == n));
    end
    finish_report(hit, nm);
  endtask

  task automatic quick_hit();
    gen_any();
    start_play();
    nivel   = 2'd0;
    posicao = alvo_m;
    for (int k = 0; k < HOLD; k++) do_tick();
    if (pontos_m < 255) pontos_m++;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit         decided;
    bit         exp_hit;
    bit         inwin;
    int         run;
    int         k;
    int         p;
    int         tol;
    logic       prev_acerto;
    logic [7:0] seq_pos[6];

    vecs[0]  = '{0, 8'd100, 8'd116, 1'b1};
    vecs[1]  = '{0, 8'd100, 8'd117, 1'b0};
    vecs[2]  = '{0, 8'd100, 8'd84,  1'b1};
    vecs[3]  = '{0, 8'd100, 8'd83,  1'b0};
    vecs[4]  = '{1, 8'd150, 8'd162, 1'b1};
    vecs[5]  = '{1, 8'd150, 8'd163, 1'b0};
    vecs[6]  = '{2, 8'd70,  8'd62,  1'b1};
    vecs[7]  = '{2, 8'd70,  8'd61,  1'b0};
    vecs[8]  = '{3, 8'd100, 8'd104, 1'b1};
    vecs[9]  = '{3, 8'd100, 8'd105, 1'b0};
    vecs[10] = '{3, 8'd191, 8'd187, 1'b1};
    vecs[11] = '{0, 8'd64,  8'd255, 1'b0};
    vecs[12] = '{2, 8'd191, 8'd0,   1'b0};

    reset = 1'b1;
    tick_ms = 1'b0;
    prep_en = 1'b0;
    gerar_nova_jogada = 1'b0;
    conta_nivel = 1'b0;
    reset_pontos = 1'b0;
    nivel = 2'd0;
    posicao = 8'd0;
    cyc();
    cyc();
    chk("rst_state", int'(db_estado), 0);
    chk("rst_pe", int'(ponto_evento), 0);
    chk("rst_acerto", int'(acerto), 0);
    chk("rst_alvo", int'(alvo), 128);
    chk("rst_pontos", int'(pontos), 0);
    chk("rst_prep_done", int'(prep_done), 0);
    reset = 1'b0;
    cyc();

    prep_en = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      for (int g = 0; g < 4; g++) begin
        cyc();
        chk("prep_gap", int'(prep_done), 0);
      end
      do_tick();
      chk("prep_tick", int'(prep_done), int'(t == PREP));
    end
    prep_en = 1'b0;
    cyc();
    prep_en = 1'b1;
    for (int t = 1; t <= PREP; t++) begin
      cyc();
      do_tick();
      chk("prep_rearm", int'(prep_done), int'(t == PREP));
    end
    prep_en = 1'b0;

    for (int i = 0; i < 13; i++) begin
      gen_target(vecs[i].tgt);
      start_play();
      const_round(vecs[i].nv, vecs[i].pos, vecs[i].hit, $sformatf("vec%0d", i));
    end

    gen_target(8'd100);
    start_play();
    nivel = 2'd3;
    seq_pos[0] = 8'd100; seq_pos[1] = 8'd103; seq_pos[2] = 8'd110;
    seq_pos[3] = 8'd96;  seq_pos[4] = 8'd104; seq_pos[5] = 8'd100;
    for (int i = 0; i < 6; i++) begin
      posicao = seq_pos[i];
      do_tick();
      chk("restart_pe", int'(ponto_evento), int'(i == 5));
    end
    finish_report(1'b1, "restart");

    prev_acerto = acerto;
    gen_any();
    start_play();
    posicao = alvo_m;
    do_tick();
    do_tick();
    conta_nivel = 1'b0;
    cyc();
    chk("abort_state", int'(db_estado), 0);
    for (int i = 0; i < 4; i++) begin
      do_tick();
      chk("abort_pe", int'(ponto_evento), 0);
    end
    chk("abort_acerto", int'(acerto), int'(prev_acerto));

    for (int r = 0; r < 40; r++) begin
      gen_any();
      start_play();
      nivel = 2'($urandom_range(0, 3));
      tol = 16 - 4 * int'(nivel);
      run = 0;
      k = 0;
      decided = 1'b0;
      exp_hit = 1'b0;
      while (!decided && k < TMO + 2) begin
        k++;
        for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
          cyc();
          chk("rnd_gap_pe", int'(ponto_evento), 0);
        end
        p = int'(alvo_m) + int'($urandom_range(0, 40)) - 20;
        if (p < 0) p = 0;
        if (p > 255) p = 255;
        posicao = 8'(p);
        inwin = ((p > int'(alvo_m)) ? p - int'(alvo_m) : int'(alvo_m) - p) <= tol;
        run = inwin ? run + 1 : 0;
        do_tick();
        if (run >= HOLD) begin
          decided = 1'b1;
          exp_hit = 1'b1;
        end else if (k >= TMO) begin
          decided = 1'b1;
        end
        chk("rnd_pe", int'(ponto_evento), int'(decided));
      end
      finish_report(exp_hit, "rnd");
    end

    while (pontos_m < 255) quick_hit();
    chk("sat_reach", int'(pontos), 255);
    quick_hit();
    chk("sat_hold", int'(pontos), 255);

    gen_any();
    start_play();
    posicao = alvo_m;
    for (int i = 0; i < HOLD; i++) do_tick();
    chk("clr_pe", int'(ponto_evento), 1);
    reset_pontos = 1'b1;
    cyc();
    reset_pontos = 1'b0;
    pontos_m = 0;
    chk("clr_wins", int'(pontos), 0);

    quick_hit();
    chk("after_clr", int'(pontos), 1);
    pontos_m = 1;

    gen_any();
    start_play();
    posicao = alvo_m;
    do_tick();
    do_tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_state", int'(db_estado), 0);
    chk("mid_rst_pe", int'(ponto_evento), 0);
    chk("mid_rst_alvo", int'(alvo), 128);
    chk("mid_rst_pontos", int'(pontos), 0);
    tick_ms = 1'b1;
    cyc();
    tick_ms = 1'b0;
    reset = 1'b0;
    pontos_m = 0;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      chk("post_rst_pe", int'(ponto_evento), 0);
      chk("post_rst_state", int'(db_estado), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
